shader_sequencer: RTL and testbench
===================================

# shader_sequencer

Program sequencer for the `shader_execute` datapath. It holds the shader program in a small register-file instruction memory, loaded byte-by-byte through a valid/ready write port. On every pixel-start pulse it streams the whole program into the datapath, one instruction per cycle, with `execute` asserted. It sits between the host/SPI loader and `shader_execute`, and the pixel-timing logic drives it.

## Interface
- `NUM_INSTR`, 8, program length in instructions; power of two, 2..32
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `pixel_start_i`  in  1  one-cycle pulse: run program for a new pixel
- `frame_start_i`  in  1  one-cycle pulse at frame boundary (bank swap point)
- `wr_valid_i`  in  1  program write request
- `wr_ready_o`  out  1  write accepted when `wr_valid_i && wr_ready_o`
- `wr_data_i`  in  8  instruction byte to write
- `wr_clear_i`  in  1  reset write pointer to 0; priority over a write in the same cycle
- `instr_o`  out  8  instruction to datapath `instr_i`
- `execute_o`  out  1  to datapath `execute`
- `busy_o`  out  1  high while in RUN
- `done_o`  out  1  one-cycle pulse after the last instruction is issued
- `overrun_o`  out  1  one-cycle pulse when `pixel_start_i` arrives during RUN

## Operation
- Memory reset value is `NOP_INSTR` = 8'h40 (AND r0,r0) in every entry of every bank.
- Write pointer `wp` has width $clog2(NUM_INSTR) and resets to 0. Each accepted write stores to `mem[wp]`, then `wp` increments and wraps from NUM_INSTR-1 to 0.
- FSM states:
  - IDLE: `execute_o`=0. On `pixel_start_i`, set `pc`=0 and go to RUN.
  - RUN: issue `mem[pc]` with `execute_o`=1. On `pc`==NUM_INSTR-1, go to IDLE and pulse `done_o` next cycle. Otherwise increment `pc`.
- `pixel_start_i` in RUN: ignored, `overrun_o` pulses for 1 cycle, and the current program continues unaffected.
- `pixel_start_i` in the cycle `done_o` is high is accepted, because the state is already IDLE. This gives back-to-back pixels with 1 idle cycle.
- `instr_o` holds the last issued value while idle and never glitches to unwritten data.
- Mid-operation reset: all outputs return to reset values immediately and the program returns to `NOP_INSTR`.

## Timing
- All outputs are registered.
- Reset values: `instr_o`=8'h40, `execute_o`=0, `busy_o`=0, `done_o`=0, `overrun_o`=0. `wr_ready_o` is 1 after reset.
- `pixel_start_i` high in cycle t:
  - `execute_o`=1 in cycles t+1..t+NUM_INSTR, carrying `mem[0]`..`mem[NUM_INSTR-1]`
  - `busy_o` matches `execute_o`
  - `done_o`=1 in cycle t+NUM_INSTR+1
- A write accepted in cycle t is visible to a program issue starting in cycle t+1 or later (non-DBUF).

## Configuration
- `SHADER_SEQ_DBUF_EN` defined:
  - Two banks, live and shadow; writes always go to shadow and `wr_ready_o` is constantly 1.
  - A write sets `pending`. `frame_start_i` with `pending` set swaps the banks, clears `pending`, and resets `wp` to 0.
  - If `frame_start_i` arrives during RUN, the swap is deferred to the first IDLE cycle, so the running program is never torn.
  - A write in the swap cycle lands in the outgoing shadow (the new live bank) at `wp`; `wp` is then 0.
- Not defined:
  - Single bank; `frame_start_i` is ignored.
  - `wr_ready_o` = !`busy_o` (registered), so writes stall during RUN.

## Structure
- `shader_pkg`: `NOP_INSTR` constant, `seq_state_t` enum {IDLE, RUN}, `INSTR_W`=8.
- One sub-module, `shader_prog_mem`: NUM_INSTR×8 register file with one write port and one async read port, reset to `NOP_INSTR`. It is instantiated twice under DBUF.

## Test plan
- Reset, then pulse start; NUM_INSTR=8 -> eight cycles of `execute_o`=1 with `instr_o`=8'h40, then `done_o` at t+9.
- Write 8'hC5, 8'h41, then 6×8'h40, then start -> `instr_o`=8'hC5 at t+1 and 8'h41 at t+2; `wp` wraps to 0.
- Start at t, second start at t+3 -> `overrun_o` at t+4, exactly 8 executes, one `done_o`. Start on the `done_o` cycle -> new run with `execute_o` gap of 1 cycle.
- Non-DBUF: hold `wr_valid_i` through a run -> `wr_ready_o`=0 for all RUN cycles, and the write completes the cycle after `busy_o` falls.
- DBUF: write a new program mid-run, then `frame_start_i` during RUN -> the current run is unchanged, the swap happens at the first IDLE cycle, and the next pixel issues the new program.
- Assert `rst_ni` low mid-run -> `execute_o`=0 and `busy_o`=0 immediately; after release, start yields all 8'h40.

Source files
------------

// File: rtl/shader_pkg.sv
// Shared types and constants for the shader program sequencer.
package shader_pkg;

    localparam int INSTR_W = 8;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 8'h40;

    typedef enum logic {
        IDLE,
        RUN
    } seq_state_t;

endpackage

// File: rtl/shader_prog_mem.sv
// Shader program register file: one write port, one async read port,
// every entry resets to NOP_INSTR.
module shader_prog_mem
    import shader_pkg::*;
#(
    parameter int NUM_INSTR = 8,
    localparam int AW = $clog2(NUM_INSTR)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [NUM_INSTR];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_INSTR; i++) begin
                mem[i] <= NOP_INSTR;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/shader_sequencer.sv
// Streams the stored shader program into shader_execute on each pixel start.
// Define SHADER_SEQ_DBUF_EN for live/shadow program banks swapped at frame start.
module shader_sequencer
    import shader_pkg::*;
#(
    parameter int NUM_INSTR = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pixel_start_i,
    input  logic               frame_start_i,
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    input  logic [INSTR_W-1:0] wr_data_i,
    input  logic               wr_clear_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic               execute_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               overrun_o
);

    localparam int AW = $clog2(NUM_INSTR);
    localparam logic [AW-1:0] LAST = AW'(NUM_INSTR - 1);

    seq_state_t         state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [AW-1:0]      wp_q, wp_d;
    logic               issue;
    logic               done_d, overrun_d;
    logic               wr_fire;
    logic               wr_ready_d;
    logic [INSTR_W-1:0] rdata;
    logic [INSTR_W-1:0] instr_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        issue     = 1'b0;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pixel_start_i) begin
                    state_d = RUN;
                    pc_d    = '0;
                    issue   = 1'b1;
                end
            end
            RUN: begin
                overrun_d = pixel_start_i;
                if (pc_q == LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    pc_d  = pc_q + 1'b1;
                    issue = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold the last issued word while idle so the datapath never sees fresh writes.
    assign instr_d = issue ? rdata : instr_o;
    assign wr_fire = wr_valid_i && wr_ready_o && !wr_clear_i;

`ifdef SHADER_SEQ_DBUF_EN
    logic               live_q;
    logic               pend_q, pend_d;
    logic               freq_q, freq_d;
    logic               req, open, swap;
    logic [INSTR_W-1:0] rdata0, rdata1;

    // Swap only in an idle cycle that does not also start a run.
    assign req  = frame_start_i || freq_q;
    assign open = (state_q == IDLE) && !pixel_start_i;
    assign swap = open && req && pend_q;

    assign freq_d     = req && !open;
    assign pend_d     = swap ? 1'b0 : (pend_q || wr_fire);
    assign wr_ready_d = 1'b1;
    assign rdata      = live_q ? rdata1 : rdata0;

    always_comb begin
        wp_d = wp_q;
        if (wr_clear_i) begin
            wp_d = '0;
        end else if (wr_fire) begin
            wp_d = wp_q + 1'b1;
        end
        if (swap) begin
            wp_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q <= 1'b0;
            pend_q <= 1'b0;
            freq_q <= 1'b0;
        end else begin
            live_q <= swap ? !live_q : live_q;
            pend_q <= pend_d;
            freq_q <= freq_d;
        end
    end

    shader_prog_mem #(
        .NUM_INSTR(NUM_INSTR)
    ) u_bank0 (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .we    (wr_fire && live_q),
        .waddr (wp_q),
        .wdata (wr_data_i),
        .raddr (pc_d),
        .rdata (rdata0)
    );

    shader_prog_mem #(
        .NUM_INSTR(NUM_INSTR)
    ) u_bank1 (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .we    (wr_fire && !live_q),
        .waddr (wp_q),
        .wdata (wr_data_i),
        .raddr (pc_d),
        .rdata (rdata1)
    );
`else
    logic unused_frame;

    assign unused_frame = frame_start_i;
    assign wr_ready_d   = (state_d != RUN);

    always_comb begin
        wp_d = wp_q;
        if (wr_clear_i) begin
            wp_d = '0;
        end else if (wr_fire) begin
            wp_d = wp_q + 1'b1;
        end
    end

    shader_prog_mem #(
        .NUM_INSTR(NUM_INSTR)
    ) u_bank0 (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .we    (wr_fire),
        .waddr (wp_q),
        .wdata (wr_data_i),
        .raddr (pc_d),
        .rdata (rdata)
    );
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= '0;
            wp_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wp_q    <= wp_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_o    <= NOP_INSTR;
            execute_o  <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            overrun_o  <= 1'b0;
            wr_ready_o <= 1'b1;
        end else begin
            instr_o    <= instr_d;
            execute_o  <= (state_d == RUN);
            busy_o     <= (state_d == RUN);
            done_o     <= done_d;
            overrun_o  <= overrun_d;
            wr_ready_o <= wr_ready_d;
        end
    end

endmodule

// File: tb/tb_shader_sequencer.sv
// Self-checking bench for shader_sequencer against a program-level model.
// Honours SHADER_SEQ_DBUF_EN when it is defined for the build.
module tb_shader_sequencer;
    import shader_pkg::*;

    localparam int N = 8;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       pixel_start_i;
    logic       frame_start_i;
    logic       wr_valid_i;
    logic       wr_ready_o;
    logic [7:0] wr_data_i;
    logic       wr_clear_i;
    logic [7:0] instr_o;
    logic       execute_o;
    logic       busy_o;
    logic       done_o;
    logic       overrun_o;

    always #5 clk_i = ~clk_i;

    shader_sequencer #(
        .NUM_INSTR(N)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .pixel_start_i(pixel_start_i),
        .frame_start_i(frame_start_i),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .wr_data_i    (wr_data_i),
        .wr_clear_i   (wr_clear_i),
        .instr_o      (instr_o),
        .execute_o    (execute_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .overrun_o    (overrun_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Program model: banks of bytes, a write cursor and a run cursor.
    logic [7:0] m_mem [2][N];
    bit         m_live;
    bit         m_run;
    bit         m_pend;
    bit         m_freq;
    int         m_idx;
    int         m_wp;
    logic [7:0] e_instr;
    bit         e_exec;
    bit         e_done;
    bit         e_over;
    bit         e_ready;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++)
                m_mem[b][i] = NOP_INSTR;
        m_live  = 0;
        m_run   = 0;
        m_pend  = 0;
        m_freq  = 0;
        m_idx   = 0;
        m_wp    = 0;
        e_instr = 8'h40;
        e_exec  = 0;
        e_done  = 0;
        e_over  = 0;
        e_ready = 1;
    endfunction

    function automatic void m_tick(bit ps, bit fs, bit wv, bit wc, logic [7:0] wd);
        bit fire;
        bit was_run;
        fire    = wv && e_ready && !wc;
        was_run = m_run;
        e_over  = ps && was_run;
        e_done  = 0;
        if (was_run) begin
            if (m_idx == N - 1) begin
                m_run  = 0;
                e_done = 1;
            end else begin
                m_idx++;
                e_instr = m_mem[m_live][m_idx];
            end
        end else if (ps) begin
            m_run   = 1;
            m_idx   = 0;
            e_instr = m_mem[m_live][0];
        end
        e_exec = m_run;
`ifdef SHADER_SEQ_DBUF_EN
        begin
            bit open;
            bit req;
            bit swap;
            open = !was_run && !ps;
            req  = fs || m_freq;
            swap = open && req && m_pend;
            if (fire) m_mem[!m_live][m_wp] = wd;
            m_freq = req && !open;
            m_pend = swap ? 1'b0 : (m_pend || fire);
            if (wc) m_wp = 0;
            else if (fire) m_wp = (m_wp + 1) % N;
            if (swap) begin
                m_wp   = 0;
                m_live = !m_live;
            end
            e_ready = 1;
        end
`else
        if (fire) m_mem[0][m_wp] = wd;
        if (wc) m_wp = 0;
        else if (fire) m_wp = (m_wp + 1) % N;
        e_ready = !m_run;
        if (fs) m_freq = 0;
`endif
    endfunction

    task automatic check_outputs();
        check("instr", 32'(instr_o), 32'(e_instr));
        check("execute", 32'(execute_o), 32'(e_exec));
        check("busy", 32'(busy_o), 32'(e_exec));
        check("done", 32'(done_o), 32'(e_done));
        check("overrun", 32'(overrun_o), 32'(e_over));
        check("wr_ready", 32'(wr_ready_o), 32'(e_ready));
    endtask

    task automatic step(bit ps, bit fs, bit wv, bit wc, logic [7:0] wd);
        pixel_start_i = ps;
        frame_start_i = fs;
        wr_valid_i    = wv;
        wr_clear_i    = wc;
        wr_data_i     = wd;
        @(posedge clk_i);
        m_tick(ps, fs, wv, wc, wd);
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        rst_ni        = 1'b0;
        pixel_start_i = 1'b0;
        frame_start_i = 1'b0;
        wr_valid_i    = 1'b0;
        wr_clear_i    = 1'b0;
        wr_data_i     = 8'h00;
        m_reset();
        @(negedge clk_i);
        check_outputs();
        rst_ni = 1'b1;
        idle(2);

        // All-NOP program after reset
        step(1, 0, 0, 0, 8'h00);
        idle(10);

        // Load C5, 41, then six NOPs; wp wraps back to 0
        step(0, 0, 1, 0, 8'hC5);
        step(0, 0, 1, 0, 8'h41);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 8'h40);
        step(0, 1, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        idle(10);

        // Overrun at t+3, then restart on the done cycle
        step(1, 0, 0, 0, 8'h00);
        idle(2);
        step(1, 0, 0, 0, 8'h00);
        idle(5);
        step(1, 0, 0, 0, 8'h00);
        idle(10);

        // Write held through a run
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 8'(8'h10 + i));
        idle(2);

        // New program written mid-run, frame start during the run
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'(8'hA0 + i));
        step(0, 1, 0, 0, 8'h00);
        idle(6);
        step(1, 0, 0, 0, 8'h00);
        idle(10);

        // Asynchronous reset mid-run
        step(1, 0, 0, 0, 8'h00);
        idle(3);
        rst_ni = 1'b0;
        #1;
        m_reset();
        check_outputs();
        #1;
        rst_ni = 1'b1;
        step(1, 0, 0, 0, 8'h00);
        idle(10);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 10) == 0,
                 ($urandom % 15) == 0,
                 ($urandom % 3) == 0,
                 ($urandom % 40) == 0,
                 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
